// File: rtl/mem_wb_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage and data memory.
//   dmem_req    stage -> mem  access request, held until acknowledged
//   dmem_we     stage -> mem  1=write, 0=read; valid with dmem_req
//   dmem_addr   stage -> mem  byte address
//   dmem_wdata  stage -> mem  store data
//   dmem_rdata  mem -> stage  load data; valid with dmem_ack
//   dmem_ack    mem -> stage  access complete; may arrive in the request cycle
interface mem_wb_stage_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;

    modport master (output dmem_req, dmem_we, dmem_addr, dmem_wdata,
                    input  dmem_rdata, dmem_ack);
    modport slave  (input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
                    output dmem_rdata, dmem_ack);
endinterface

// File: rtl/mem_wb_stage.sv
// MEM stage plus MEM/WB pipeline register.
// Resolves branches, runs loads/stores over the req/ack data-memory bus,
// stalls the front of the pipe while an access is outstanding and registers
// results for writeback. A misaligned access or a bus timeout parks the
// stage in a fatal error state that only reset leaves.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   wbM, memM, brnchDstM, zFlagM, alu_outM, rtM, wrDstM   EX/MEM register
//   pcSrc, brnchTgt            branch resolution (combinational)
//   stall                      hold front of pipe this cycle (combinational)
//   bus_err                    sticky fatal error
//   bus                        data-memory bus (master side)
//   wbW, rdDataW, alu_outW, wrDstW                        MEM/WB register
module mem_wb_stage #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [1:0]    wbM,
    input  logic [2:0]    memM,
    input  logic [31:0]   brnchDstM,
    input  logic          zFlagM,
    input  logic [31:0]   alu_outM,
    input  logic [31:0]   rtM,
    input  logic [4:0]    wrDstM,
    output logic          pcSrc,
    output logic [31:0]   brnchTgt,
    output logic          stall,
    output logic          bus_err,
    mem_wb_stage_if.master bus,
    output logic [1:0]    wbW,
    output logic [31:0]   rdDataW,
    output logic [31:0]   alu_outW,
    output logic [4:0]    wrDstW
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_ERR  = 2'd2;

    logic [1:0]       state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             acc, mis, req, in_err, rd_done;

    assign acc    = memM[1] | memM[0];
    assign mis    = acc & (alu_outM[1:0] != 2'b00);
    assign in_err = (state == S_ERR);

    assign pcSrc    = memM[2] & zFlagM & ~in_err;
    assign brnchTgt = brnchDstM;
    assign bus_err  = in_err;

    // Write wins when both MemRead and MemWrite are set.
    assign bus.dmem_req   = req;
    assign bus.dmem_we    = memM[0];
    assign bus.dmem_addr  = alu_outM;
    assign bus.dmem_wdata = rtM;

    assign stall = (acc & ~bus.dmem_ack & ~in_err) | in_err | (acc & mis);

    // A completed read always has stall=0 (req&ack implies aligned, not ERR).
    assign rd_done = req & bus.dmem_ack & memM[1] & ~memM[0];

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        req      = 1'b0;
        case (state)
            S_IDLE: begin
                req = acc & ~mis;
                if (acc & mis) begin
                    state_nx = S_ERR;
                end else if (req & ~bus.dmem_ack) begin
                    state_nx = S_WAIT;
                    cnt_nx   = CNT_W'(1);
                end
            end
            S_WAIT: begin
                // EX/MEM is frozen by stall, so address and data stay put.
                req = 1'b1;
                if (bus.dmem_ack)
                    state_nx = S_IDLE;
                else if (cnt == CNT_W'(TIMEOUT))
                    state_nx = S_ERR;
                else
                    cnt_nx = cnt + CNT_W'(1);
            end
            S_ERR:   ;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            wbW      <= '0;
            rdDataW  <= '0;
            alu_outW <= '0;
            wrDstW   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (stall) begin
                wbW <= 2'b00;   // bubble into writeback
            end else begin
                wbW      <= wbM;
                alu_outW <= alu_outM;
                wrDstW   <= wrDstM;
                if (rd_done)
                    rdDataW <= bus.dmem_rdata;
            end
        end
    end
endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  wbM = '0;
    logic [2:0]  memM = '0;
    logic [31:0] brnchDstM = '0;
    logic        zFlagM = 1'b0;
    logic [31:0] alu_outM = '0;
    logic [31:0] rtM = '0;
    logic [4:0]  wrDstM = '0;
    logic        pcSrc, stall, bus_err;
    logic [31:0] brnchTgt, rdDataW, alu_outW;
    logic [1:0]  wbW;
    logic [4:0]  wrDstW;

    int errors = 0;
    int checks = 0;

    mem_wb_stage_if bus ();

    mem_wb_stage #(.TIMEOUT(16), .CNT_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .wbM(wbM), .memM(memM),
        .brnchDstM(brnchDstM), .zFlagM(zFlagM), .alu_outM(alu_outM),
        .rtM(rtM), .wrDstM(wrDstM), .pcSrc(pcSrc), .brnchTgt(brnchTgt),
        .stall(stall), .bus_err(bus_err), .bus(bus), .wbW(wbW),
        .rdDataW(rdDataW), .alu_outW(alu_outW), .wrDstW(wrDstW)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs change 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        wbM = '0; memM = '0; zFlagM = 1'b0; alu_outM = '0; rtM = '0; wrDstM = '0;
        bus.dmem_ack = 1'b0; bus.dmem_rdata = '0;
    endtask

    initial begin
        idle_in();
        // Reset state
        #12;
        chk("rst_wbW", wbW, 0);
        chk("rst_rdDataW", rdDataW, 0);
        chk("rst_alu_outW", alu_outW, 0);
        chk("rst_wrDstW", wrDstW, 0);
        chk("rst_bus_err", bus_err, 0);
        chk("rst_stall", stall, 0);
        chk("rst_req", bus.dmem_req, 0);
        @(negedge clk); rst_n = 1'b1;
        tick();

        // 1: zero-wait load
        wbM = 2'b11; memM = 3'b010; alu_outM = 32'h10; wrDstM = 5'd5;
        bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'hDEADBEEF;
        #3;
        chk("lw0_stall", stall, 0);
        chk("lw0_req", bus.dmem_req, 1);
        chk("lw0_we", bus.dmem_we, 0);
        chk("lw0_addr", bus.dmem_addr, 32'h10);
        tick();
        chk("lw0_wbW", wbW, 2'b11);
        chk("lw0_rdDataW", rdDataW, 32'hDEADBEEF);
        chk("lw0_alu_outW", alu_outW, 32'h10);
        chk("lw0_wrDstW", wrDstW, 5);

        // ack with no request is ignored
        idle_in();
        wbM = 2'b11; wrDstM = 5'd7;
        bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'hCAFEF00D;
        #3;
        chk("noreq_req", bus.dmem_req, 0);
        chk("noreq_stall", stall, 0);
        tick();
        chk("noreq_rdDataW", rdDataW, 32'hDEADBEEF);
        chk("noreq_wrDstW", wrDstW, 7);

        // 4: branch resolution
        idle_in();
        memM = 3'b100; zFlagM = 1'b1; brnchDstM = 32'h40;
        #3;
        chk("beq_pcSrc", pcSrc, 1);
        chk("beq_tgt", brnchTgt, 32'h40);
        chk("beq_stall", stall, 0);
        zFlagM = 1'b0;
        #1;
        chk("beq_nt_pcSrc", pcSrc, 0);
        tick();

        // 2: store acked 3 cycles late (RegWrite set so bubbles are visible)
        idle_in();
        wbM = 2'b10; memM = 3'b001; alu_outM = 32'h20; rtM = 32'h1234; wrDstM = 5'd9;
        for (int i = 0; i < 3; i++) begin
            #3;
            chk($sformatf("sw_stall%0d", i), stall, 1);
            chk($sformatf("sw_req%0d", i), bus.dmem_req, 1);
            chk($sformatf("sw_we%0d", i), bus.dmem_we, 1);
            chk($sformatf("sw_addr%0d", i), bus.dmem_addr, 32'h20);
            chk($sformatf("sw_wdata%0d", i), bus.dmem_wdata, 32'h1234);
            tick();
            chk($sformatf("sw_bubble%0d", i), wbW, 0);
        end
        bus.dmem_ack = 1'b1;
        #3;
        chk("sw_ack_stall", stall, 0);
        chk("sw_ack_req", bus.dmem_req, 1);
        tick();
        idle_in();
        chk("sw_wbW", wbW, 2'b10);
        chk("sw_alu_outW", alu_outW, 32'h20);
        chk("sw_wrDstW", wrDstW, 9);
        chk("sw_rdDataW_hold", rdDataW, 32'hDEADBEEF);

        // 5: reset mid-WAIT
        wbM = 2'b11; memM = 3'b010; alu_outM = 32'h30; wrDstM = 5'd3;
        tick();
        chk("rw_wait_stall", stall, 1);
        chk("rw_wait_req", bus.dmem_req, 1);
        rst_n = 1'b0;
        #1;
        chk("rw_rdDataW", rdDataW, 0);
        chk("rw_alu_outW", alu_outW, 0);
        chk("rw_wrDstW", wrDstW, 0);
        chk("rw_wbW", wbW, 0);
        chk("rw_bus_err", bus_err, 0);
        memM = 3'b000;
        #1;
        chk("rw_req_idle", bus.dmem_req, 0);
        chk("rw_stall_idle", stall, 0);
        @(negedge clk); rst_n = 1'b1;
        tick();

        // 3: load never acked -> timeout after 16 WAIT cycles
        wbM = 2'b11; memM = 3'b010; alu_outM = 32'h40; wrDstM = 5'd4;
        tick();  // now in WAIT, cnt=1
        for (int i = 1; i < 16; i++) tick();
        #2;
        chk("to_last_wait_err", bus_err, 0);
        chk("to_last_wait_req", bus.dmem_req, 1);
        tick();
        chk("to_bus_err", bus_err, 1);
        chk("to_req", bus.dmem_req, 0);
        chk("to_stall", stall, 1);
        idle_in();
        memM = 3'b100; zFlagM = 1'b1;
        #1;
        chk("err_pcSrc", pcSrc, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("err_stall%0d", i), stall, 1);
            chk($sformatf("err_wbW%0d", i), wbW, 0);
        end
        idle_in();
        rst_n = 1'b0;
        #1;
        chk("err_rst_bus_err", bus_err, 0);
        chk("err_rst_stall", stall, 0);
        @(negedge clk); rst_n = 1'b1;
        tick();

        // 6: misaligned store
        wbM = 2'b00; memM = 3'b001; alu_outM = 32'h22; rtM = 32'h55;
        #1;
        chk("mis_req", bus.dmem_req, 0);
        chk("mis_stall", stall, 1);
        chk("mis_bus_err0", bus_err, 0);
        tick();
        chk("mis_bus_err1", bus_err, 1);
        chk("mis_req1", bus.dmem_req, 0);
        idle_in();
        rst_n = 1'b0;
        #1;
        chk("mis_rst_bus_err", bus_err, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
